// File: rtl/pwm_multi.sv
// pwm_multi: N-channel PWM generator sharing one prescaler and one R-bit
// period counter. Duty values are double-buffered and take effect only at
// period boundaries. Counting is edge-aligned or center-aligned, chosen per
// period.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-low reset
//   dvsr         prescaler divisor, one count tick every dvsr+1 clocks
//   duty         packed duty values, channel i at [i*(R+1) +: R+1]
//   load         strobe: capture duty into the pending buffer
//   mode         0 = edge-aligned, 1 = center-aligned (applied at boundary)
//   inv          per-channel output inversion (unbuffered)
//   pwm_out      registered PWM outputs
//   period_start one-clock pulse on the first output cycle of each period
module pwm_multi #(
  parameter int unsigned R = 8,
  parameter int unsigned N = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        dvsr,
  input  logic [N*(R+1)-1:0] duty,
  input  logic               load,
  input  logic               mode,
  input  logic [N-1:0]       inv,
  output logic [N-1:0]       pwm_out,
  output logic               period_start
);

  localparam int unsigned DW = R + 1;
  localparam logic [R-1:0] DMAX = '1;

  logic [31:0]             pre_q, pre_d;
  logic [R-1:0]            cnt_q, cnt_d;
  logic                    up_q, up_d;
  logic                    mode_act_q, mode_act_d;
  logic [N-1:0][DW-1:0]    pend_q, pend_d;
  logic [N-1:0][DW-1:0]    act_q, act_d;
  logic                    pflag_q, pflag_d;
  logic                    bnd_q;
  logic                    ps_q;
  logic [N-1:0]            pwm_q, pwm_d;
  logic                    tick_c;
  logic                    bnd_c;

  // State registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_q      <= '0;
      cnt_q      <= '0;
      up_q       <= 1'b1;
      mode_act_q <= 1'b0;
      pend_q     <= '0;
      act_q      <= '0;
      pflag_q    <= 1'b0;
      bnd_q      <= 1'b0;
      ps_q       <= 1'b0;
      pwm_q      <= '0;
    end else begin
      pre_q      <= pre_d;
      cnt_q      <= cnt_d;
      up_q       <= up_d;
      mode_act_q <= mode_act_d;
      pend_q     <= pend_d;
      act_q      <= act_d;
      pflag_q    <= pflag_d;
      bnd_q      <= bnd_c;
      ps_q       <= bnd_q;
      pwm_q      <= pwm_d;
    end
  end

  // Prescaler, period counter and boundary detection
  always_comb begin
    tick_c     = (pre_q == '0);
    // >= so that lowering dvsr below the current count wraps immediately
    pre_d      = (pre_q >= dvsr) ? '0 : pre_q + 32'd1;
    cnt_d      = cnt_q;
    up_d       = up_q;
    mode_act_d = mode_act_q;
    bnd_c      = 1'b0;
    if (tick_c) begin
      if (!mode_act_q) begin
        if (cnt_q == DMAX) bnd_c = 1'b1;
        else               cnt_d = cnt_q + R'(1);
      end else if (up_q) begin
        if (cnt_q == DMAX) begin
          cnt_d = DMAX - R'(1);
          up_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + R'(1);
        end
      end else begin
        if (cnt_q == R'(1)) bnd_c = 1'b1;
        else                cnt_d = cnt_q - R'(1);
      end
      if (bnd_c) begin
        cnt_d      = '0;
        up_d       = 1'b1;
        mode_act_d = mode;
      end
    end
  end

  // Duty double-buffer; a load on a boundary cycle stays pending for the next one
  always_comb begin
    pend_d  = pend_q;
    act_d   = act_q;
    pflag_d = pflag_q;
    if (bnd_c && pflag_q) begin
      act_d   = pend_q;
      pflag_d = 1'b0;
    end
    if (load) begin
      for (int unsigned i = 0; i < N; i++) begin
        pend_d[i] = duty[i*DW +: DW];
      end
      pflag_d = 1'b1;
    end
  end

  // Compare; act >= 2^R is always above the counter, giving constant high
  always_comb begin
    pwm_d = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pwm_d[i] = ({1'b0, cnt_q} < act_q[i]) ^ inv[i];
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = ps_q;

endmodule
